// File: rtl/hack_mem_loader.sv
// hack_mem_loader: loads a framed UART byte stream into Hack memory and holds the CPU in reset until a frame checks out.
// Optional readback verify of each written word is built when HACK_MEM_LOADER_READBACK_EN is defined.
module hack_mem_loader #(
  parameter int          ADDR_W         = 14,
  parameter int          WIDTH          = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_d,
  input  logic [WIDTH-1:0]  mem_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);
  localparam int IW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, ERROR} state_t;
  state_t state, nxt;
  logic [7:0]    len_hi, hi, chk;
  logic [IW-1:0] len, idx;
  logic [TW-1:0] tmr;
  logic [15:0]   len_w;
  logic          timeout, rb_fail, take;
  assign len_w   = {len_hi, rx_data};
  assign timeout = busy && !rx_valid && tmr == TW'(TIMEOUT_CYCLES - 1);
  assign take    = rx_valid && !rb_fail;
`ifdef HACK_MEM_LOADER_READBACK_EN
  // mem_addr/mem_d are still held on the cycle after a write, so mem_q reflects the stored word
  logic rb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rb <= 1'b0;
    else rb <= mem_we;
  assign rb_fail = rb && mem_q != mem_d;
`else
  logic unused_q;
  assign unused_q = ^mem_q;
  assign rb_fail  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (rb_fail || timeout) nxt = ERROR;
    else if (state == ERROR) nxt = IDLE;
    else if (rx_valid)
      case (state)
        IDLE:    nxt = rx_data == SYNC_BYTE ? LEN_HI : IDLE;
        LEN_HI:  nxt = LEN_LO;
        LEN_LO:  nxt = len_w == 16'd0 ? CHECK : {1'b0, len_w} > MAX_LEN ? ERROR : DATA_HI;
        DATA_HI: nxt = DATA_LO;
        DATA_LO: nxt = idx + IW'(1) == len ? CHECK : DATA_HI;
        CHECK:   nxt = rx_data == chk ? IDLE : ERROR;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    busy     = state != IDLE && state != ERROR;
    cpu_hold = !done;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_d    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      len_hi   <= '0;
      hi       <= '0;
      chk      <= '0;
      len      <= '0;
      idx      <= '0;
      tmr      <= '0;
    end else begin
      mem_we <= take && state == DATA_LO;
      tmr    <= (!busy || rx_valid) ? '0 : tmr + TW'(1);
      if (take) begin
        chk <= state == IDLE ? 8'h00 : chk ^ rx_data;
        if (state == IDLE && rx_data == SYNC_BYTE) begin
          done <= 1'b0;
          err  <= 1'b0;
          idx  <= '0;
        end
        if (state == LEN_HI) len_hi <= rx_data;
        if (state == LEN_LO) len <= len_w[IW-1:0];
        if (state == DATA_HI) hi <= rx_data;
        if (state == DATA_LO) begin
          mem_addr <= idx[ADDR_W-1:0];
          mem_d    <= {hi, rx_data};
          idx      <= idx + IW'(1);
        end
        if (state == CHECK && rx_data == chk) done <= 1'b1;
      end
      if (nxt == ERROR) begin
        err  <= 1'b1;
        done <= 1'b0;
      end
    end
endmodule
